ps2_kbd_rx_fifo: RTL

Parametrised PS/2 keyboard receiver with a scan-code FIFO: synchronises and edge-detects `ps2_clk`, deserialises 11-bit frames, checks framing and odd parity, and buffers valid scan codes in a configurable-depth first-word-fall-through FIFO. Compared with the previous receiver, it adds full-depth FIFO use via an occupancy counter, an occupancy output, sticky error flags, and an idle-timeout frame resynchroniser. It sits between the PS/2 pins and the keyboard scan-code/ASCII decode logic.

---
 rtl/ps2_kbd_rx_fifo.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_rx_fifo.sv
// ps2_kbd_rx_fifo
// PS/2 keyboard receiver feeding a first-word-fall-through scan-code FIFO.
// Frames are 11 bits (start, 8 data LSB-first, odd parity, stop). Valid
// scan codes are queued; full/empty comes from an occupancy counter so every
// entry is usable. Sticky flags report overflow, bad framing/parity and
// frames abandoned by the idle timeout.
//
// Optional build macro: PS2_CLK_FILTER_EN
//    defined   -> ps2_clk glitch filter of FILTER_LEN cycles after the synchroniser
//    undefined -> edge detection runs straight off the synchroniser
//
// Reset (i_clr) is synchronous, active-high. FIFO storage is never cleared.

module ps2_kbd_rx_fifo #(
   parameter int DEPTH_LOG2     = 3,
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int FILTER_LEN     = 4
) (
   input  logic                  i_clk,
   input  logic                  i_clr,
   input  logic                  i_ps2_clk,
   input  logic                  i_ps2_data,
   input  logic                  i_nextdata_n,
   output logic [7:0]            o_data,
   output logic                  o_ready,
   output logic [DEPTH_LOG2:0]   o_level,
   output logic                  o_overflow,
   output logic                  o_parity_err,
   output logic                  o_frame_err
);

   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

   // synchronisers: [0] first stage, [1] middle, [2] last
   logic [2:0]            r_ps2c_sync;
   logic [1:0]            r_ps2d_sync;

   logic [3:0]            r_count;
   logic [9:0]            r_buffer;
   logic [IDLE_W-1:0]     r_idle;
   logic                  r_overflow;
   logic                  r_parity_err;
   logic                  r_frame_err;

   logic [7:0]            r_fifo [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wptr;
   logic [DEPTH_LOG2-1:0] r_rptr;
   logic [DEPTH_LOG2:0]   r_level;

   logic                  w_sampling;
   logic                  w_ps2_data;
   logic                  w_stop_edge;
   logic                  w_frame_ok;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_push;

   // Bring the asynchronous PS/2 pins into the clk domain; idle level is high
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_ps2c_sync <= 3'b111;
         r_ps2d_sync <= 2'b11;
      end else begin
         r_ps2c_sync <= {r_ps2c_sync[1:0], i_ps2_clk};
         r_ps2d_sync <= {r_ps2d_sync[0], i_ps2_data};
      end
   end

   // data's second stage lines up with the middle clock stage
   assign w_ps2_data = r_ps2d_sync[1];

`ifdef PS2_CLK_FILTER_EN
   localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [FLT_W-1:0] r_flt_cnt;
   logic             r_flt;
   logic             r_flt_d;

   // Glitch filter: follow the synchronised clock only after it holds a new
   // value for FILTER_LEN consecutive cycles
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_flt_cnt <= '0;
         r_flt     <= 1'b1;
         r_flt_d   <= 1'b1;
      end else begin
         r_flt_d <= r_flt;
         if (r_ps2c_sync[1] != r_flt) begin
            if (r_flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
               r_flt     <= r_ps2c_sync[1];
               r_flt_cnt <= '0;
            end else begin
               r_flt_cnt <= r_flt_cnt + 1'b1;
            end
         end else begin
            r_flt_cnt <= '0;
         end
      end
   end

   assign w_sampling = r_flt_d & ~r_flt;
`else
   // falling edge: older stage still high, newer stage low
   assign w_sampling = r_ps2c_sync[2] & ~r_ps2c_sync[1];
`endif

   assign w_stop_edge = w_sampling && (r_count == 4'd10);
   assign w_frame_ok  = ~r_buffer[0] & w_ps2_data & (^r_buffer[9:1]);
   assign w_full      = (r_level == (DEPTH_LOG2 + 1)'(DEPTH));
   assign w_pop       = o_ready & ~i_nextdata_n;
   assign w_push      = w_stop_edge & w_frame_ok & (~w_full | w_pop);

   // Deserialiser, frame check, idle timeout and sticky error flags
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_count      <= '0;
         r_buffer     <= '0;
         r_idle       <= '0;
         r_overflow   <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else if (w_sampling) begin
         r_idle <= '0;
         if (r_count == 4'd10) begin
            r_count <= '0;
            if (!w_frame_ok)
               r_parity_err <= 1'b1;
            else if (w_full && !w_pop)
               r_overflow <= 1'b1;
         end else begin
            r_buffer[r_count] <= w_ps2_data;
            r_count           <= r_count + 4'd1;
         end
      end else if (r_count != 4'd0) begin
         // a stalled sender leaves a partial frame; drop it and resync
         if (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            r_count     <= '0;
            r_idle      <= '0;
            r_frame_err <= 1'b1;
         end else begin
            r_idle <= r_idle + 1'b1;
         end
      end else begin
         r_idle <= '0;
      end
   end

   // FIFO pointers and occupancy; level alone decides full/empty
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)
            r_level <= r_level + 1'b1;
         else if (w_pop && !w_push)
            r_level <= r_level - 1'b1;
      end
   end

   // FIFO storage is left untouched by reset
   always_ff @(posedge i_clk) begin
      if (w_push)
         r_fifo[r_wptr] <= r_buffer[8:1];
   end

   assign o_data       = r_fifo[r_rptr];
   assign o_ready      = (r_level != '0);
   assign o_level      = r_level;
   assign o_overflow   = r_overflow;
   assign o_parity_err = r_parity_err;
   assign o_frame_err  = r_frame_err;

endmodule
